// File: rtl/systolic_pkg.sv
// Shared widths, tile geometry and FSM encoding for the systolic tile loader.
// Pure declarations: no latency, no backpressure.
package systolic_pkg;
  localparam int DATA_W    = 8;
  localparam int IMG_WORDS = 16;
  localparam int FLT_WORDS = 9;
  localparam int IDX_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_F,
    LOAD_I,
    CLEAR,
    RUN,
    OUT
  } state_t;
endpackage

// File: rtl/tile_operand_regs.sv
// Indexed byte-write register file holding the image tile and filter as flat buses.
// Latency: a write appears on i_flat/f_flat the cycle after wr_en. No backpressure.
module tile_operand_regs
  import systolic_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         wr_flt,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [DATA_W-1:0]            wr_dat,
  output logic [IMG_WORDS*DATA_W-1:0]  i_flat,
  output logic [FLT_WORDS*DATA_W-1:0]  f_flat
);

  // Word 0 sits in the most significant byte of each bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_flat <= '0;
      f_flat <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < FLT_WORDS; k++) begin
        if (wr_flt && wr_idx == IDX_W'(k)) f_flat[(FLT_WORDS-1-k)*DATA_W +: DATA_W] <= wr_dat;
      end
      for (int k = 0; k < IMG_WORDS; k++) begin
        if (!wr_flt && wr_idx == IDX_W'(k)) i_flat[(IMG_WORDS-1-k)*DATA_W +: DATA_W] <= wr_dat;
      end
    end
  end

endmodule

// File: rtl/systolic_tile_loader.sv
// Loads a 3x3 filter + 4x4 tile into two_by_two_systolic, resets it, samples o_res after SETTLE_CYC.
// Latency: last beat at t -> m_valid at t+2+SETTLE_CYC. TILE_LOADER_FRAME_CHECK_EN adds s_last framing checks.
// Backpressure: s_ready low from CLEAR until the result is handshaken; m_valid held until m_ready.
module systolic_tile_loader
  import systolic_pkg::*;
#(
  parameter int SETTLE_CYC = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  input  logic         s_last,
  input  logic         flt_keep,
  output logic [127:0] i_flat,
  output logic [71:0]  f_flat,
  output logic         arr_rst,
  input  logic [31:0]  o_res,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] FLT_LAST    = IDX_W'(FLT_WORDS - 1);
  localparam logic [IDX_W-1:0] IMG_LAST    = IDX_W'(IMG_WORDS - 1);

  state_t           state;
  logic [IDX_W-1:0] wcnt;
  logic [CW-1:0]    scnt;
  logic             loading, beat, wr_flt, last_word, frame_abort, missing_last;
  logic [IDX_W-1:0] wr_idx;

  assign loading   = (state == IDLE) || (state == LOAD_F) || (state == LOAD_I);
  assign beat      = s_valid & s_ready & loading;
  assign wr_flt    = (state == IDLE) ? ~flt_keep : (state == LOAD_F);
  assign wr_idx    = (state == IDLE) ? '0 : wcnt;
  assign last_word = (state == LOAD_I) && (wcnt == IMG_LAST);

`ifdef TILE_LOADER_FRAME_CHECK_EN
  assign frame_abort  = s_last & ~last_word;
  assign missing_last = ~s_last;
`else
  logic unused_last;
  assign unused_last  = s_last;
  assign frame_abort  = 1'b0;
  assign missing_last = 1'b0;
`endif

  tile_operand_regs u_regs (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (beat),
    .wr_flt (wr_flt),
    .wr_idx (wr_idx),
    .wr_dat (s_data),
    .i_flat (i_flat),
    .f_flat (f_flat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      scnt    <= '0;
      s_ready <= 1'b0;
      arr_rst <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          wcnt    <= IDX_W'(1);
          if (beat) begin
            if (frame_abort) err <= 1'b1;
            else begin
              state <= flt_keep ? LOAD_I : LOAD_F;
              busy  <= 1'b1;
            end
          end
        end
        LOAD_F: if (beat) begin
          if (frame_abort) begin
            err   <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wcnt == FLT_LAST) begin
            state <= LOAD_I;
            wcnt  <= '0;
          end else wcnt <= wcnt + IDX_W'(1);
        end
        LOAD_I: if (beat) begin
          if (frame_abort) begin
            err   <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last_word) begin
            state   <= CLEAR;
            s_ready <= 1'b0;
            err     <= missing_last;
          end else wcnt <= wcnt + IDX_W'(1);
        end
        CLEAR: begin
          state   <= RUN;
          arr_rst <= 1'b0;
          scnt    <= '0;
        end
        RUN: begin
          if (scnt == SETTLE_LAST) begin
            m_data  <= o_res;
            m_valid <= 1'b1;
            arr_rst <= 1'b1;
            state   <= OUT;
          end else scnt <= scnt + CW'(1);
        end
        OUT: if (m_ready) begin
          m_valid <= 1'b0;
          busy    <= 1'b0;
          s_ready <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_tile_loader.sv
// Bench for systolic_tile_loader with a behavioural 2x2 convolution array and a result scoreboard.
module tb_systolic_tile_loader;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [7:0]   s_data = 8'd0;
  logic         s_last = 1'b0;
  logic         flt_keep = 1'b0;
  logic [127:0] i_flat;
  logic [71:0]  f_flat;
  logic         arr_rst;
  logic [31:0]  o_res;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_data;
  logic         busy;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int settle = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  cur_f[9];
  logic [7:0]  cur_i[16];
  logic [7:0]  tb_flt[9];

  systolic_tile_loader #(.SETTLE_CYC(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .flt_keep(flt_keep), .i_flat(i_flat), .f_flat(f_flat),
    .arr_rst(arr_rst), .o_res(o_res), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] conv(input logic [7:0] f[9], input logic [7:0] im[16]);
    logic [7:0]  acc;
    logic [31:0] r;
    r = '0;
    for (int r0 = 0; r0 < 2; r0++)
      for (int c0 = 0; c0 < 2; c0++) begin
        acc = 8'd0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            acc = acc + 8'(f[i*3+j] * im[(r0+i)*4 + c0 + j]);
        r[(3 - (r0*2 + c0))*8 +: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [31:0] conv_flat(input logic [127:0] iv, input logic [71:0] fv);
    logic [7:0] f[9];
    logic [7:0] im[16];
    for (int k = 0; k < 9; k++)  f[k]  = fv[(8-k)*8 +: 8];
    for (int k = 0; k < 16; k++) im[k] = iv[(15-k)*8 +: 8];
    return conv(f, im);
  endfunction

  function automatic logic [71:0] pack_f(input logic [7:0] f[9]);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[(8-k)*8 +: 8] = f[k];
    return r;
  endfunction

  function automatic logic [127:0] pack_i(input logic [7:0] im[16]);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[(15-k)*8 +: 8] = im[k];
    return r;
  endfunction

  // Array stand-in: outputs zero while held in reset and until it has settled a few cycles.
  always @(posedge clk or posedge arr_rst)
    if (arr_rst) settle <= 0;
    else if (settle < 100) settle <= settle + 1;
  assign o_res = (!arr_rst && settle >= 6) ? conv_flat(i_flat, f_flat) : 32'h0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_s1();
    cur_f = '{8'd3, 8'd2, 8'd0, 8'd2, 8'd0, 8'd1, 8'd3, 8'd1, 8'd1};
    cur_i = '{8'd9, 8'd8, 8'd2, 8'd6, 8'd0, 8'd4, 8'd1, 8'd6,
              8'd4, 8'd10, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd9};
  endtask

  task automatic send_frame(input bit keep, input bit rnd, input int last_at, input int stop_at,
                            output int c_last);
    logic [7:0] words[$];
    int n, idx, guard;
    bit v;
    words = {};
    if (!keep) for (int k = 0; k < 9; k++) words.push_back(cur_f[k]);
    for (int k = 0; k < 16; k++) words.push_back(cur_i[k]);
    n = (stop_at >= 0) ? stop_at + 1 : words.size();
    if (stop_at < 0) begin
      if (!keep) tb_flt = cur_f;
      exp_q.push_back(conv(tb_flt, cur_i));
    end
    idx = 0; guard = 0; c_last = cyc;
    while (idx < n && guard < 400) begin
      @(negedge clk);
      n_cmp++;
      if (arr_rst !== 1'b1) begin
        n_bad++;
        $display("FAIL load_arr_rst: arr_rst=%b required 1 before beat %0d", arr_rst, idx);
      end
      v = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_valid  = v;
      s_data   = words[idx];
      flt_keep = keep;
      s_last   = (last_at >= 0) ? (idx == last_at) : (idx == n - 1);
      if (v && s_ready === 1'b1) begin
        c_last = cyc;
        idx++;
      end
      guard++;
    end
    if (idx < n) begin
      n_cmp++; n_bad++;
      $display("FAIL load_timeout: %0d beats accepted, required %0d", idx, n);
    end
  endtask

  task automatic collect(input int c_last, input int hold);
    int g;
    logic [31:0] d0, expv;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = (hold == 0);
    n_cmp++;
    if (arr_rst !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_state: arr_rst=%b s_ready=%b busy=%b required 1 0 1", arr_rst, s_ready, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (arr_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL run_arr_rst: arr_rst=%b required 0", arr_rst);
    end
    g = 0;
    while (m_valid !== 1'b1 && g < 60) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (cyc - c_last != 18) begin
      n_bad++;
      $display("FAIL latency: m_valid after %0d cycles, required 18", cyc - c_last);
    end
    if (m_valid !== 1'b1) return;
    d0 = m_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== d0 || s_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold: m_valid=%b m_data=%h s_ready=%b required 1 %h 0", m_valid, m_data, s_ready, d0);
      end
    end
    m_ready = 1'b1;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL result_unexpected: m_data=%h with empty scoreboard", m_data);
    end else begin
      expv = exp_q.pop_front();
      if (m_data !== expv) begin
        n_bad++;
        $display("FAIL result_data: m_data=%h required %h", m_data, expv);
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release: m_valid=%b busy=%b s_ready=%b required 0 0 1", m_valid, busy, s_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b0 || arr_rst !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: s_ready=%b arr_rst=%b m_valid=%b busy=%b err=%b required 0 1 0 0 0",
               s_ready, arr_rst, m_valid, busy, err);
    end
    n_cmp++;
    if (i_flat !== 128'h0 || f_flat !== 72'h0 || m_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: i_flat=%h f_flat=%h m_data=%h required zeros", i_flat, f_flat, m_data);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || arr_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_after_reset: s_ready=%b busy=%b arr_rst=%b required 1 0 1", s_ready, busy, arr_rst);
    end
  endtask

  task automatic test_full_frame();
    int cl;
    set_s1();
    send_frame(1'b0, 1'b0, -1, -1, cl);
    collect(cl, 0);
  endtask

  task automatic test_keep_filter();
    int cl;
    for (int k = 0; k < 16; k++) cur_i[k] = 8'd1;
    send_frame(1'b1, 1'b0, -1, -1, cl);
    collect(cl, 0);
    n_cmp++;
    if (f_flat !== pack_f(tb_flt)) begin
      n_bad++;
      $display("FAIL keep_filter: f_flat=%h required %h", f_flat, pack_f(tb_flt));
    end
    n_cmp++;
    if (i_flat !== pack_i(cur_i)) begin
      n_bad++;
      $display("FAIL keep_image: i_flat=%h required %h", i_flat, pack_i(cur_i));
    end
  endtask

  task automatic test_backpressure();
    int cl;
    set_s1();
    send_frame(1'b0, 1'b0, -1, -1, cl);
    collect(cl, 20);
  endtask

  task automatic test_random_valid();
    int cl;
    set_s1();
    send_frame(1'b0, 1'b1, -1, -1, cl);
    collect(cl, 0);
  endtask

`ifdef TILE_LOADER_FRAME_CHECK_EN
  task automatic test_frame_error();
    int cl;
    bit seen;
    set_s1();
    send_frame(1'b1, 1'b0, 4, 4, cl);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pulse: err=%b busy=%b required 1 0", err, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_width: err=%b required 0", err);
    end
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (m_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL err_drop: m_valid_seen=%b s_ready=%b required 0 1", seen, s_ready);
    end
    n_cmp++;
    if (f_flat !== pack_f(tb_flt)) begin
      n_bad++;
      $display("FAIL err_filter: f_flat=%h required %h", f_flat, pack_f(tb_flt));
    end
    send_frame(1'b0, 1'b0, -1, -1, cl);
    collect(cl, 0);
  endtask
`else
  task automatic test_last_ignored();
    int cl;
    set_s1();
    send_frame(1'b0, 1'b0, 4, -1, cl);
    collect(cl, 0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_tied: err=%b required 0", err);
    end
  endtask
`endif

  task automatic test_async_reset();
    int cl;
    set_s1();
    send_frame(1'b0, 1'b0, -1, -1, cl);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (arr_rst !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_run: arr_rst=%b busy=%b required 0 1", arr_rst, busy);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (arr_rst !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: arr_rst=%b m_valid=%b busy=%b s_ready=%b required 1 0 0 0",
               arr_rst, m_valid, busy, s_ready);
    end
    n_cmp++;
    if (f_flat !== 72'h0 || i_flat !== 128'h0) begin
      n_bad++;
      $display("FAIL async_reset_regs: f_flat=%h i_flat=%h required zeros", f_flat, i_flat);
    end
    if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    for (int k = 0; k < 9; k++) tb_flt[k] = 8'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_frame(1'b0, 1'b0, -1, -1, cl);
    collect(cl, 0);
  endtask

  initial begin
    for (int k = 0; k < 9; k++) tb_flt[k] = 8'd0;
    test_reset();
    test_full_frame();
    test_keep_filter();
    test_backpressure();
    test_random_valid();
`ifdef TILE_LOADER_FRAME_CHECK_EN
    test_frame_error();
`else
    test_last_ignored();
`endif
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
